ultrasonic_echo_responder: RTL and testbench
============================================

// Module: ultrasonic_echo_responder
// PURPOSE
//  Sensor-side model of the trigger/echo ranging interface: the responder that the ultrasonic
//  ranging controller talks to. Detects a valid trigger pulse, waits the acoustic burst time,
//  then drives echo high for a width proportional to the programmed distance.
//  Used in place of the physical sensor for board bring-up and as a bench model for the controller.
// PARAMETERS
//  CLK_HZ       50_000_000  clock frequency; CYC_US = CLK_HZ/1_000_000 cycles per us
//  MIN_TRIG_US  10          minimum trigger high width accepted
//  BURST_US     200         delay from accepted trigger fall to echo rise
//  US_PER_CM    58          echo width per cm of distance (round trip)
//  MIN_CM       2           distance clamp, lower
//  MAX_CM       400         distance clamp, upper
//  TIMEOUT_US   38000       echo width when no object present
//  HOLDOFF_US   10000       dead time after echo fall before next trigger accepted
// PORTS
//  clk               in   1  system clock
//  rst               in   1  asynchronous reset, active-high
//  trigger_i         in   1  trigger from ranging controller (asynchronous)
//  distance_cm_i     in   9  simulated target distance, cm
//  object_present_i  in   1  1 = target present, 0 = return timeout-width echo
//  echo_o            out  1  echo pulse to ranging controller
//  busy_o            out  1  high in any state other than IDLE/TRIG_HI
//  trig_short_o      out  1  1-cycle pulse: trigger rejected as too short
//  trig_ignored_o    out  1  1-cycle pulse: trigger rise seen while busy
// BEHAVIOUR
//  - trigger_i passes a 2-FF synchronizer, then a 1-FF edge-detect register (3-cycle input latency).
//  - Reset (any time, incl. mid-echo): all outputs 0, state IDLE, counters 0; echo_o drops immediately.
//  - FSM states: IDLE, TRIG_HI, BURST, ECHO, HOLDOFF.
//  - IDLE: on synced rise -> TRIG_HI, width counter cleared then counts each cycle trig is high.
//  - TRIG_HI: on synced fall: width >= MIN_TRIG_US*CYC_US -> BURST, latch distance_cm_i and
//    object_present_i at that cycle; else pulse trig_short_o, -> IDLE. Width counter saturates.
//  - BURST: count BURST_US*CYC_US cycles -> ECHO. echo_o rises exactly 3+BURST_US*CYC_US
//    cycles after the first clock edge at which trigger_i is sampled low.
//  - ECHO: echo_o high for W cycles, then -> HOLDOFF with echo_o low.
//    W = clamp(d, MIN_CM, MAX_CM) * US_PER_CM * CYC_US if object latched present,
//    W = TIMEOUT_US * CYC_US otherwise. Product computed at full width (>=22 bits at defaults),
//    no truncation; d = 0 gives MIN_CM width, d > MAX_CM gives MAX_CM width.
//  - HOLDOFF: HOLDOFF_US*CYC_US cycles -> IDLE.
//  - Synced trigger rise in BURST/ECHO/HOLDOFF: pulse trig_ignored_o, no state change; that pulse
//    is never accepted even if still high on return to IDLE (a fresh rise is required).
//  - Input changes to distance_cm_i/object_present_i after latching do not affect current echo.
//  - Trigger held high indefinitely: stay in TRIG_HI, no echo.
//  - busy_o high exactly in BURST, ECHO, HOLDOFF. Outputs registered, glitch-free.
// TESTING (sim params: CLK_HZ=1_000_000, BURST_US=200, HOLDOFF_US=1000, TIMEOUT_US=38000)
//  1. trigger_i high 10 cycles, distance 10, present=1 -> echo_o rises 203 cycles after
//     trigger fall, high exactly 580 cycles; busy_o high from BURST through HOLDOFF.
//  2. trigger_i high 9 cycles -> trig_short_o single pulse, echo_o stays 0, FSM back to IDLE.
//  3. distance 0 then 511, present=1 -> echo widths 116 and 23200 cycles.
//  4. present=0, distance 100 -> echo width 38000 cycles.
//  5. second 10-cycle trigger 50 cycles into echo -> one trig_ignored_o pulse, first echo width
//     unchanged, no second echo; trigger issued after HOLDOFF -> normal echo.
//  6. rst asserted mid-echo -> echo_o and busy_o 0 immediately; next valid trigger after
//     release gives a correct 580-cycle echo for distance 10.

Source files
------------

// File: rtl/ultrasonic_echo_responder.sv
// Purpose : sensor-side model of an ultrasonic trigger/echo ranger; accepts a trigger pulse of
//           sufficient width, waits the burst time, then drives echo for a distance-proportional width.
// Latency : trigger_i -> internal edge 3 cycles; echo rises 3+BURST cycles after trigger is sampled low.
// Backpressure: none; triggers arriving while busy are reported on trig_ignored_o and dropped.
// Ports   : clk/rst (async, active-high); trigger_i (async), distance_cm_i, object_present_i in;
//           echo_o, busy_o, trig_short_o, trig_ignored_o out (all registered).
module ultrasonic_echo_responder #(
    parameter int CLK_HZ      = 50_000_000,
    parameter int MIN_TRIG_US = 10,
    parameter int BURST_US    = 200,
    parameter int US_PER_CM   = 58,
    parameter int MIN_CM      = 2,
    parameter int MAX_CM      = 400,
    parameter int TIMEOUT_US  = 38000,
    parameter int HOLDOFF_US  = 10000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       trigger_i,
    input  logic [8:0] distance_cm_i,
    input  logic       object_present_i,
    output logic       echo_o,
    output logic       busy_o,
    output logic       trig_short_o,
    output logic       trig_ignored_o
);

    localparam int CYC_US      = CLK_HZ / 1_000_000;
    localparam int TRIG_MIN    = MIN_TRIG_US * CYC_US;
    localparam int BURST_CYC   = BURST_US * CYC_US;
    localparam int HOLD_CYC    = HOLDOFF_US * CYC_US;
    localparam int TIMEOUT_CYC = TIMEOUT_US * CYC_US;
    localparam int CM_CYC      = US_PER_CM * CYC_US;
    localparam int TW          = $clog2(TRIG_MIN + 2);

    typedef enum logic [2:0] {IDLE, TRIG_HI, BURST, ECHO, HOLDOFF} state_t;

    state_t        state;
    logic          sync1, sync2, trig_q;
    logic [TW-1:0] width_cnt;
    logic [31:0]   cnt;
    logic [8:0]    dist_q;
    logic          pres_q;
    logic [8:0]    dist_cl;
    logic [31:0]   echo_len;
    logic          rise, fall;

    assign rise = sync2 & ~trig_q;
    assign fall = ~sync2 & trig_q;

    // Echo width from the values latched at trigger acceptance, full 32-bit product.
    always_comb begin
        dist_cl = dist_q;
        if (dist_q < 9'(MIN_CM))
            dist_cl = 9'(MIN_CM);
        else if (dist_q > 9'(MAX_CM))
            dist_cl = 9'(MAX_CM);
        echo_len = pres_q ? (32'(dist_cl) * 32'(CM_CYC)) : 32'(TIMEOUT_CYC);
    end

    // Two-stage synchronizer followed by the edge-detect register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            trig_q <= 1'b0;
        end else begin
            sync1  <= trigger_i;
            sync2  <= sync1;
            trig_q <= sync2;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            width_cnt      <= '0;
            cnt            <= '0;
            dist_q         <= '0;
            pres_q         <= 1'b0;
            echo_o         <= 1'b0;
            busy_o         <= 1'b0;
            trig_short_o   <= 1'b0;
            trig_ignored_o <= 1'b0;
        end else begin
            trig_short_o   <= 1'b0;
            trig_ignored_o <= rise && (state == BURST || state == ECHO || state == HOLDOFF);
            case (state)
                IDLE: begin
                    // The rising-edge cycle itself is the first high cycle of the pulse.
                    if (rise) begin
                        state     <= TRIG_HI;
                        width_cnt <= TW'(1);
                    end
                end
                TRIG_HI: begin
                    if (fall) begin
                        if (width_cnt >= TW'(TRIG_MIN)) begin
                            state  <= BURST;
                            busy_o <= 1'b1;
                            dist_q <= distance_cm_i;
                            pres_q <= object_present_i;
                            cnt    <= '0;
                        end else begin
                            state        <= IDLE;
                            trig_short_o <= 1'b1;
                        end
                    end else if (sync2 && width_cnt < TW'(TRIG_MIN)) begin
                        width_cnt <= width_cnt + TW'(1);
                    end
                end
                BURST: begin
                    // Terminal count of BURST_CYC (not -1): the extra cycle covers the
                    // edge-detect stage so echo lands 3+BURST cycles after trigger low.
                    if (cnt == 32'(BURST_CYC)) begin
                        state  <= ECHO;
                        echo_o <= 1'b1;
                        cnt    <= '0;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                ECHO: begin
                    if (cnt == echo_len - 32'd1) begin
                        state  <= HOLDOFF;
                        echo_o <= 1'b0;
                        cnt    <= '0;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                HOLDOFF: begin
                    if (cnt == 32'(HOLD_CYC) - 32'd1) begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                        cnt    <= '0;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                    echo_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ultrasonic_echo_responder.sv
// Purpose : bench for ultrasonic_echo_responder with a queue-based scoreboard and reference model.
// Latency : expected echo rise 203 cycles after trigger sampled low at the sim parameters.
// Backpressure: n/a; stimulus waits out each echo plus holdoff before the next accepted trigger.
module tb_ultrasonic_echo_responder;

    logic       clk = 1'b0;
    logic       rst;
    logic       trigger_i;
    logic [8:0] distance_cm_i;
    logic       object_present_i;
    logic       echo_o, busy_o, trig_short_o, trig_ignored_o;

    ultrasonic_echo_responder #(
        .CLK_HZ(1_000_000), .BURST_US(200), .HOLDOFF_US(1000), .TIMEOUT_US(38000)
    ) dut (
        .clk(clk), .rst(rst), .trigger_i(trigger_i), .distance_cm_i(distance_cm_i),
        .object_present_i(object_present_i), .echo_o(echo_o), .busy_o(busy_o),
        .trig_short_o(trig_short_o), .trig_ignored_o(trig_ignored_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int t_rise;
        int width;
    } echo_exp_t;

    echo_exp_t exp_echo[$];
    int        exp_short[$];
    int        exp_ign[$];
    int        total = 0;
    int        bad = 0;
    int        cyc = 0;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic unexpected(input string name);
        total++;
        bad++;
        $display("FAIL %s: output pulse with no expectation at cycle %0d", name, cyc);
    endtask

    // Reference: sensor answers with the round-trip time of the clamped distance, or a timeout.
    function automatic int ref_width(input int d, input bit p);
        int dc;
        if (!p) return 38000;
        dc = (d < 2) ? 2 : ((d > 400) ? 400 : d);
        return dc * 58;
    endfunction

    // Monitor: samples 1 time unit after each rising edge and checks against the queues.
    initial begin : monitor
        bit in_echo;
        bit tracked;
        int rise_t;
        in_echo = 1'b0;
        tracked = 1'b0;
        rise_t  = 0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (rst) begin
                in_echo = 1'b0;
            end else begin
                if (trig_short_o) begin
                    if (exp_short.size() == 0) unexpected("short_pulse");
                    else check("short_pulse_time", cyc, exp_short.pop_front());
                end
                if (trig_ignored_o) begin
                    if (exp_ign.size() == 0) unexpected("ignored_pulse");
                    else check("ignored_pulse_time", cyc, exp_ign.pop_front());
                end
                if (echo_o && !in_echo) begin
                    in_echo = 1'b1;
                    rise_t  = cyc;
                    check("busy_during_echo", int'(busy_o), 1);
                    if (exp_echo.size() == 0) begin
                        tracked = 1'b0;
                        unexpected("echo");
                    end else begin
                        tracked = 1'b1;
                        check("echo_rise_time", cyc, exp_echo[0].t_rise);
                    end
                end else if (!echo_o && in_echo) begin
                    in_echo = 1'b0;
                    if (tracked) begin
                        check("echo_width", cyc - rise_t, exp_echo[0].width);
                        void'(exp_echo.pop_front());
                    end
                end
            end
        end
    end

    // Trigger high for 'hi' sampled cycles; the expectation is queued at the falling drive.
    task automatic send(input int hi, input int d, input bit p);
        echo_exp_t e;
        @(negedge clk);
        distance_cm_i    = 9'(d);
        object_present_i = p;
        trigger_i        = 1'b1;
        repeat (hi) @(negedge clk);
        trigger_i = 1'b0;
        if (hi >= 10) begin
            e.t_rise = cyc + 1 + 203;
            e.width  = ref_width(d, p);
            exp_echo.push_back(e);
        end else begin
            exp_short.push_back(cyc + 1 + 2);
        end
        // Scramble inputs after they have been latched; the echo must not follow them.
        repeat (5) @(negedge clk);
        distance_cm_i    = 9'($urandom_range(0, 511));
        object_present_i = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_done(input int w);
        repeat (203 + w + 1000 + 5) @(negedge clk);
    endtask

    initial begin : watchdog
        #(98_000 * 10);
        $display("FAIL watchdog: run exceeded cycle budget, cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        rst              = 1'b1;
        trigger_i        = 1'b0;
        distance_cm_i    = '0;
        object_present_i = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_echo", int'(echo_o), 0);
        check("reset_busy", int'(busy_o), 0);
        check("reset_short", int'(trig_short_o), 0);
        check("reset_ignored", int'(trig_ignored_o), 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Basic 10 cm ranging and busy window.
        send(10, 10, 1'b1);
        check("busy_in_burst", int'(busy_o), 1);
        repeat (198 + 580 + 500) @(negedge clk);
        check("busy_in_holdoff", int'(busy_o), 1);
        check("echo_low_in_holdoff", int'(echo_o), 0);
        repeat (510) @(negedge clk);
        check("busy_idle", int'(busy_o), 0);

        // Short trigger is rejected.
        send(9, 10, 1'b1);
        repeat (10) @(negedge clk);
        check("busy_after_short", int'(busy_o), 0);
        check("echo_after_short", int'(echo_o), 0);

        // Clamp boundaries and no-object timeout.
        send(10, 0, 1'b1);
        wait_done(116);
        send(10, 511, 1'b1);
        wait_done(23200);
        send(10, 100, 1'b0);
        wait_done(38000);

        // Trigger during echo is ignored; a later one is served normally.
        send(10, 10, 1'b1);
        repeat (248) @(negedge clk);
        @(negedge clk);
        trigger_i = 1'b1;
        exp_ign.push_back(cyc + 1 + 2);
        repeat (10) @(negedge clk);
        trigger_i = 1'b0;
        repeat (1780) @(negedge clk);
        check("busy_after_ignored", int'(busy_o), 0);
        send(10, 10, 1'b1);
        wait_done(580);

        // Randomized widths and distances.
        for (int i = 0; i < 4; i++) begin
            int hi;
            int d;
            hi = $urandom_range(6, 13);
            d  = $urandom_range(0, 25);
            send(hi, d, 1'b1);
            if (hi >= 10) wait_done(ref_width(d, 1'b1));
            else repeat (10) @(negedge clk);
        end

        // Reset in the middle of an echo.
        send(10, 10, 1'b1);
        repeat (300) @(negedge clk);
        rst = 1'b1;
        #1;
        check("reset_mid_echo_echo", int'(echo_o), 0);
        check("reset_mid_echo_busy", int'(busy_o), 0);
        exp_echo.delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        send(10, 10, 1'b1);
        wait_done(580);

        check("echo_queue_empty", exp_echo.size(), 0);
        check("short_queue_empty", exp_short.size(), 0);
        check("ignored_queue_empty", exp_ign.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
